// File: rtl/demux_pkg.sv
// Shared constants and types for the stream demultiplexer.
//   DEFAULT_WIDTH / DEFAULT_N_OUT / DEFAULT_CNT_W : default parameter values
//   slot_state_e                                  : per-channel slot occupancy
package demux_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned DEFAULT_N_OUT = 4;
    localparam int unsigned DEFAULT_CNT_W = 8;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/demux_slot.sv
// One-entry output slot for a single demux channel.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   load       : write data_in into the slot this cycle (only asserted while free)
//   data_in    : payload to capture
//   ready      : downstream consumer ready
//   valid      : slot holds a word
//   data_out   : held word, stable while FULL and not transferred
//   free       : slot can take a word this cycle (empty, or full and draining)
module demux_slot
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data_out,
    output logic             free
);

    slot_state_e      state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    // Next-state logic; a reload wins over a drain so back-to-back words keep the slot FULL
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        unique case (state_q)
            EMPTY: begin
                if (load) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (load) begin
                    state_d = FULL;
                end else if (ready) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (load) begin
            data_d = data_in;
        end
    end

    // Outputs
    always_comb begin
        valid    = (state_q == FULL);
        free     = (state_q == EMPTY) || ready;
        data_out = data_q;
    end

endmodule

// File: rtl/stream_demux.sv
// Valid/ready stream demultiplexer with per-channel one-entry slots.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   in_valid   : upstream word present
//   in_ready   : word accepted this cycle
//   in_data    : payload
//   in_sel     : destination channel (values >= N_OUT are dropped and counted)
//   in_bcast   : copy the word to every channel, in_sel ignored
//   out_valid  : per-channel word present
//   out_ready  : per-channel consumer ready
//   out_data   : per-channel payload, channel 0 in the LSBs
//   drop_cnt   : saturating count of words dropped for an invalid in_sel
module stream_demux
    import demux_pkg::*;
#(
    parameter  int unsigned WIDTH = DEFAULT_WIDTH,
    parameter  int unsigned N_OUT = DEFAULT_N_OUT,
    parameter  int unsigned CNT_W = DEFAULT_CNT_W,
    localparam int unsigned SEL_W = $clog2(N_OUT)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    input  logic [SEL_W-1:0]       in_sel,
    input  logic                   in_bcast,
    output logic [N_OUT-1:0]       out_valid,
    input  logic [N_OUT-1:0]       out_ready,
    output logic [N_OUT*WIDTH-1:0] out_data,
    output logic [CNT_W-1:0]       drop_cnt
);

    // One extra bit so that N_OUT itself is representable for the range compare
    localparam logic [SEL_W:0] N_OUT_L = (SEL_W + 1)'(N_OUT);

    logic [N_OUT-1:0] free;
    logic [N_OUT-1:0] load;
    logic             sel_ok;
    logic             tgt_free;
    logic             accept;
    logic             drop;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    // Select decode and handshake. in_ready depends only on in_sel, in_bcast and slot state /
    // out_ready, never on in_data.
    always_comb begin
        sel_ok   = ({1'b0, in_sel} < N_OUT_L);
        tgt_free = 1'b0;
        for (int i = 0; i < int'(N_OUT); i++) begin
            if (in_sel == SEL_W'(i)) begin
                tgt_free = free[i];
            end
        end

        if (in_bcast) begin
            in_ready = &free;
        end else if (!sel_ok) begin
            in_ready = 1'b1;
        end else begin
            in_ready = tgt_free;
        end

        accept = in_valid && in_ready;
        drop   = accept && !in_bcast && !sel_ok;

        load = '0;
        for (int i = 0; i < int'(N_OUT); i++) begin
            load[i] = accept && (in_bcast || (sel_ok && (in_sel == SEL_W'(i))));
        end
    end

    // Saturating drop counter
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != {CNT_W{1'b1}})) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;

    for (genvar g = 0; g < N_OUT; g++) begin : g_slot
        demux_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clk      (clk),
            .rst      (rst),
            .load     (load[g]),
            .data_in  (in_data),
            .ready    (out_ready[g]),
            .valid    (out_valid[g]),
            .data_out (out_data[g*WIDTH +: WIDTH]),
            .free     (free[g])
        );
    end

endmodule

// File: doc/stream_demux.md
STREAM_DEMUX -- requirements
Module: stream_demux

Interface
REQ-001 The block SHALL take parameter WIDTH, default 8, as the data width in bits (WIDTH >= 1).
REQ-002 The block SHALL take parameter N_OUT, default 4, as the output channel count (2..16).
REQ-003 The block SHALL take parameter CNT_W, default 8, as the drop-counter width.
REQ-004 The block SHALL derive SEL_W = $clog2(N_OUT) as a localparam, never set by the user.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 in_valid  input  1  upstream word present.
REQ-008 in_ready  output  1  block accepts the word this cycle.
REQ-009 in_data  input  WIDTH  payload.
REQ-010 in_sel  input  SEL_W  destination channel index.
REQ-011 in_bcast  input  1  copy the word to all channels; in_sel is ignored.
REQ-012 out_valid  output  N_OUT  per-channel word present.
REQ-013 out_ready  input  N_OUT  per-channel consumer ready.
REQ-014 out_data  output  N_OUT x WIDTH  per-channel payload, packed, channel 0 in the LSBs.
REQ-015 drop_cnt  output  CNT_W  count of words dropped for invalid in_sel.

Function
REQ-016 Each channel SHALL hold a one-entry slot with states EMPTY and FULL; out_valid[i] = (slot i FULL).
REQ-017 A transfer SHALL occur on a channel when out_valid[i] && out_ready[i]; slot i then goes EMPTY unless it is reloaded in the same cycle.
REQ-018 Slot i SHALL be "free" when it is EMPTY, or when it is FULL with out_ready[i]=1 (same-cycle drain and refill).
REQ-019 When in_bcast=0 and in_sel < N_OUT, in_ready SHALL equal free[in_sel].
REQ-020 When in_bcast=1, in_ready SHALL be the AND of free[i] over all channels.
REQ-021 When in_bcast=0 and in_sel >= N_OUT, in_ready SHALL be 1; the word SHALL be discarded and drop_cnt incremented.
REQ-022 drop_cnt SHALL saturate at 2^CNT_W-1.
REQ-023 An accepted word (in_valid && in_ready) SHALL appear on out_valid/out_data of the target channel(s) on the next cycle: 1-cycle latency.
REQ-024 Full throughput SHALL be supported: one word per cycle when the target is continuously ready.
REQ-025 out_data[i] SHALL remain stable while slot i is FULL and not transferred.
REQ-026 in_ready SHALL have no combinational dependence on in_data.
REQ-027 in_ready MAY depend combinationally on in_sel, in_bcast and out_ready.
REQ-028 Words for different channels SHALL never be reordered relative to acceptance order per channel.
REQ-029 Only the addressed slot(s) SHALL change on acceptance; other slots SHALL hold or drain independently.

Reset
REQ-030 On rst=1, all slots SHALL go EMPTY asynchronously: out_valid=0, out_data=0, drop_cnt=0.
REQ-031 in_ready SHALL follow REQ-019..021 from the reset values; mid-operation reset SHALL discard all held words.
REQ-032 The first acceptance SHALL be possible on the first rising edge after rst deasserts.

Structure
REQ-033 Package demux_pkg SHALL hold the default WIDTH, N_OUT and CNT_W constants and the slot state enum {EMPTY, FULL}.
REQ-034 The per-channel one-entry register SHALL be sub-module demux_slot (ports: clk, rst, load, data_in, ready, valid, data_out, free), instantiated N_OUT times via generate.
REQ-035 Select decode, broadcast AND and drop counter SHALL live in stream_demux.

Verification
REQ-036 Reset, then in_sel=2, data=0xA5, valid held one cycle with out_ready=all 1 -> out_valid=4'b0100 and out_data[2]=0xA5 next cycle, gone the cycle after.
REQ-037 out_ready[1]=0; send 0x11 then 0x22 to channel 1 -> in_ready=0 on the second word until out_ready[1]=1; then 0x11 is delivered, 0x22 is accepted the same cycle and appears next cycle.
REQ-038 in_bcast=1, data=0x3C, channel 3 stalled and full -> in_ready=0; release channel 3 -> all four out_valid=1 with 0x3C one cycle later.
REQ-039 N_OUT=3, in_sel=3, 300 consecutive valid words -> in_ready=1 throughout, no out_valid, drop_cnt saturates at 255.
REQ-040 Assert rst asynchronously mid-cycle with channels 0 and 2 full -> out_valid=0 and drop_cnt=0 immediately, without waiting for a clock edge.
REQ-041 Random stream with random out_ready (WIDTH=16, N_OUT=8) -> per-channel scoreboard matches order and data, and throughput is 1 word/cycle when all channels are ready.
